// File: rtl/cmd_frame_ctrl.sv
// UART command-frame controller for the REF clock domain: decodes write, read and ALU frames,
// drives the register file and ALU, and returns results to the TX FIFO one byte at a time, LSB byte first.
module cmd_frame_ctrl #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int ALU_OUT_WIDTH  = 16,
   parameter int OPA_ADDR       = 0,
   parameter int OPB_ADDR       = 1,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter logic [DATA_WIDTH-1:0] WR_CMD      = 'hAA,
   parameter logic [DATA_WIDTH-1:0] RD_CMD      = 'hBB,
   parameter logic [DATA_WIDTH-1:0] ALU_OP_CMD  = 'hCC,
   parameter logic [DATA_WIDTH-1:0] ALU_NOP_CMD = 'hDD
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
   input  logic                     RX_D_VLD,
   input  logic [DATA_WIDTH-1:0]    RdData,
   input  logic                     RdData_Valid,
   input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
   input  logic                     OUT_Valid,
   input  logic                     TX_FULL,
   output logic                     ALU_EN,
   output logic [3:0]               ALU_FUN,
   output logic                     CLK_EN,
   output logic [ADDR_WIDTH-1:0]    Address,
   output logic                     WrEn,
   output logic                     RdEn,
   output logic [DATA_WIDTH-1:0]    WrData,
   output logic [DATA_WIDTH-1:0]    TX_P_DATA,
   output logic                     TX_D_VLD,
   output logic                     BUSY,
   output logic                     FRAME_ERR
);

   localparam int NB     = (ALU_OUT_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
   localparam int BUF_W  = NB * DATA_WIDTH;
   localparam int CW     = $clog2(NB + 1);
   localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
   localparam int TW     = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0] TMO_LAST = TMO_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [3:0] {
      S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT,
      S_ALU_A, S_ALU_B, S_ALU_F, S_ALU_WAIT, S_TX_SEND
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
   logic [3:0]              alu_fun_q, alu_fun_d;
   logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
   logic [BUF_W-1:0]        buf_q, buf_d;
   logic [CW-1:0]           left_q, left_d;
   logic [TW-1:0]           tmo_q, tmo_d;
   logic                    wr_en_q, wr_en_d;
   logic                    rd_en_q, rd_en_d;
   logic                    alu_en_q, alu_en_d;
   logic                    clk_en_q, clk_en_d;
   logic                    tx_vld_q, tx_vld_d;
   logic                    busy_q, busy_d;
   logic                    err_q, err_d;
   logic                    accept;

   // NOTE: every variable gets its hold/idle value first so no path through the case infers a latch.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wr_data_d = wr_data_q;
      alu_fun_d = alu_fun_q;
      tx_data_d = tx_data_q;
      buf_d     = buf_q;
      left_d    = left_q;
      tmo_d     = '0;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      alu_en_d  = 1'b0;
      tx_vld_d  = 1'b0;
      err_d     = 1'b0;
      accept    = 1'b0;

      case (state_q)
         S_IDLE: if (RX_D_VLD) begin
            if      (RX_P_DATA == WR_CMD)      state_d = S_WR_ADDR;
            else if (RX_P_DATA == RD_CMD)      state_d = S_RD_ADDR;
            else if (RX_P_DATA == ALU_OP_CMD)  state_d = S_ALU_A;
            else if (RX_P_DATA == ALU_NOP_CMD) state_d = S_ALU_F;
            else                               err_d   = 1'b1;
         end
         S_WR_ADDR: if (RX_D_VLD) begin
            accept  = 1'b1;
            addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
            state_d = S_WR_DATA;
         end
         S_WR_DATA: if (RX_D_VLD) begin
            accept    = 1'b1;
            wr_en_d   = 1'b1;
            wr_data_d = RX_P_DATA;
            state_d   = S_IDLE;
         end
         S_RD_ADDR: if (RX_D_VLD) begin
            accept  = 1'b1;
            rd_en_d = 1'b1;
            addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
            state_d = S_RD_WAIT;
         end
         S_RD_WAIT: if (RdData_Valid) begin
            accept  = 1'b1;
            buf_d   = BUF_W'(RdData);
            left_d  = CW'(1);
            state_d = S_TX_SEND;
         end
         S_ALU_A, S_ALU_B: if (RX_D_VLD) begin
            accept    = 1'b1;
            wr_en_d   = 1'b1;
            wr_data_d = RX_P_DATA;
            addr_d    = (state_q == S_ALU_A) ? ADDR_WIDTH'(OPA_ADDR) : ADDR_WIDTH'(OPB_ADDR);
            state_d   = (state_q == S_ALU_A) ? S_ALU_B : S_ALU_F;
         end
         S_ALU_F: if (RX_D_VLD) begin
            accept    = 1'b1;
            alu_en_d  = 1'b1;
            alu_fun_d = RX_P_DATA[3:0];
            state_d   = S_ALU_WAIT;
         end
         S_ALU_WAIT: if (OUT_Valid) begin
            accept  = 1'b1;
            buf_d   = BUF_W'(ALU_OUT);
            left_d  = CW'(NB);
            state_d = S_TX_SEND;
         end
         S_TX_SEND: if (!TX_FULL) begin
            tx_vld_d  = 1'b1;
            tx_data_d = buf_q[DATA_WIDTH-1:0];
            buf_d     = buf_q >> DATA_WIDTH;
            left_d    = left_q - CW'(1);
            if (left_q == CW'(1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Bytes arriving while a response is pending are dropped, not queued.
      if (RX_D_VLD && (state_q == S_RD_WAIT || state_q == S_ALU_WAIT || state_q == S_TX_SEND))
         err_d = 1'b1;

      // The watchdog only runs while waiting on the host or on the register file / ALU.
      if (state_q != S_IDLE && state_q != S_TX_SEND && !accept) begin
         if (TMO_EN && tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
         end else if (TMO_EN) begin
            tmo_d = tmo_q + TW'(1);
         end
      end

      clk_en_d = (state_d == S_ALU_F) || (state_d == S_ALU_WAIT);
      busy_d   = (state_d != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the TX buffer and byte count are reset too, so a reset mid-response can never leak stale bytes.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         wr_data_q <= '0;
         alu_fun_q <= '0;
         tx_data_q <= '0;
         buf_q     <= '0;
         left_q    <= '0;
         tmo_q     <= '0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         alu_en_q  <= 1'b0;
         clk_en_q  <= 1'b0;
         tx_vld_q  <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wr_data_q <= wr_data_d;
         alu_fun_q <= alu_fun_d;
         tx_data_q <= tx_data_d;
         buf_q     <= buf_d;
         left_q    <= left_d;
         tmo_q     <= tmo_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
         alu_en_q  <= alu_en_d;
         clk_en_q  <= clk_en_d;
         tx_vld_q  <= tx_vld_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
      end
   end

   assign ALU_EN    = alu_en_q;
   assign ALU_FUN   = alu_fun_q;
   assign CLK_EN    = clk_en_q;
   assign Address   = addr_q;
   assign WrEn      = wr_en_q;
   assign RdEn      = rd_en_q;
   assign WrData    = wr_data_q;
   assign TX_P_DATA = tx_data_q;
   assign TX_D_VLD  = tx_vld_q;
   assign BUSY      = busy_q;
   assign FRAME_ERR = err_q;

endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// Scoreboard bench for cmd_frame_ctrl: expected strobes are queued as frames are driven and
// matched by a monitor that samples the DUT 1 ns after each rising clock edge.
module tb_cmd_frame_ctrl;

   logic        CLK;
   logic        RST;
   logic [7:0]  RX_P_DATA;
   logic        RX_D_VLD;
   logic [7:0]  RdData;
   logic        RdData_Valid;
   logic [15:0] ALU_OUT;
   logic        OUT_Valid;
   logic        TX_FULL;
   logic        ALU_EN;
   logic [3:0]  ALU_FUN;
   logic        CLK_EN;
   logic [3:0]  Address;
   logic        WrEn;
   logic        RdEn;
   logic [7:0]  WrData;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD;
   logic        BUSY;
   logic        FRAME_ERR;

   cmd_frame_ctrl #(.TIMEOUT_CYCLES(16)) dut (
      .CLK(CLK), .RST(RST),
      .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .RdData(RdData), .RdData_Valid(RdData_Valid),
      .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
      .TX_FULL(TX_FULL),
      .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN),
      .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
      .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
      .BUSY(BUSY), .FRAME_ERR(FRAME_ERR)
   );

   typedef struct packed {
      logic [3:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t        exp_wr[$];
   logic [3:0] exp_rd[$];
   logic [3:0] exp_alu[$];
   logic [7:0] exp_tx[$];
   int         exp_err;
   int         n_checks;
   int         n_fail;
   int         tx_seen;
   logic       full_at_edge;
   wr_t        e_wr;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] all_outputs();
      return 32'({ALU_EN, ALU_FUN, CLK_EN, Address, WrEn, RdEn, WrData, TX_P_DATA, TX_D_VLD, BUSY, FRAME_ERR});
   endfunction

   // Monitor: every strobe must match the head of its scoreboard queue.
   always @(posedge CLK) begin
      full_at_edge = TX_FULL;
      #1;
      if (WrEn) begin
         check("wr_pending", 32'(exp_wr.size() != 0), 1);
         if (exp_wr.size() != 0) begin
            e_wr = exp_wr.pop_front();
            check("wr_addr", 32'(Address), 32'(e_wr.addr));
            check("wr_data", 32'(WrData), 32'(e_wr.data));
         end
      end
      if (RdEn) begin
         check("rd_pending", 32'(exp_rd.size() != 0), 1);
         if (exp_rd.size() != 0) check("rd_addr", 32'(Address), 32'(exp_rd.pop_front()));
      end
      if (ALU_EN) begin
         check("alu_pending", 32'(exp_alu.size() != 0), 1);
         if (exp_alu.size() != 0) check("alu_fun", 32'(ALU_FUN), 32'(exp_alu.pop_front()));
      end
      if (TX_D_VLD) begin
         tx_seen++;
         check("tx_while_full", 32'(full_at_edge), 0);
         check("tx_pending", 32'(exp_tx.size() != 0), 1);
         if (exp_tx.size() != 0) check("tx_byte", 32'(TX_P_DATA), 32'(exp_tx.pop_front()));
      end
      if (FRAME_ERR) begin
         check("err_pending", 32'(exp_err != 0), 1);
         if (exp_err != 0) exp_err--;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge CLK);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      @(negedge CLK);
      RX_D_VLD  = 1'b0;
   endtask

   task automatic rd_valid(input logic [7:0] d);
      @(negedge CLK);
      RdData       = d;
      RdData_Valid = 1'b1;
      @(negedge CLK);
      RdData_Valid = 1'b0;
   endtask

   task automatic out_valid(input logic [15:0] r);
      @(negedge CLK);
      ALU_OUT   = r;
      OUT_Valid = 1'b1;
      @(negedge CLK);
      OUT_Valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK);
         if (!BUSY && exp_tx.size() == 0 && exp_wr.size() == 0 && exp_rd.size() == 0 &&
             exp_alu.size() == 0 && exp_err == 0) break;
      end
      check({tag, "_busy"}, 32'(BUSY), 0);
      check({tag, "_drain"}, 32'(exp_tx.size() + exp_wr.size() + exp_rd.size() + exp_alu.size() + exp_err), 0);
   endtask

   initial begin
      int cyc;
      int tx_mark;
      n_checks = 0; n_fail = 0; exp_err = 0; tx_seen = 0;
      RST = 1'b1; RX_P_DATA = '0; RX_D_VLD = 1'b0; RdData = '0; RdData_Valid = 1'b0;
      ALU_OUT = '0; OUT_Valid = 1'b0; TX_FULL = 1'b0;
      repeat (3) @(negedge CLK);
      check("reset_outputs", all_outputs(), 0);
      RST = 1'b0;

      // Write frame
      exp_wr.push_back('{addr: 4'h5, data: 8'h3C});
      send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
      check("wr_busy_after", 32'(BUSY), 0);
      repeat (3) @(negedge CLK);
      check("hold_addr", 32'(Address), 32'h5);
      check("hold_wrdata", 32'(WrData), 32'h3C);
      wait_idle("write");

      // Read frame, data returned two cycles after RdEn
      exp_rd.push_back(4'h5);
      exp_tx.push_back(8'h3C);
      send_byte(8'hBB); send_byte(8'h05);
      check("rd_busy", 32'(BUSY), 1);
      rd_valid(8'h3C);
      wait_idle("read");

      // ALU frame with operand writes and a two-byte result
      exp_wr.push_back('{addr: 4'h0, data: 8'h12});
      exp_wr.push_back('{addr: 4'h1, data: 8'h34});
      exp_alu.push_back(4'h2);
      exp_tx.push_back(8'h26); exp_tx.push_back(8'h04);
      check("clken_idle", 32'(CLK_EN), 0);
      send_byte(8'hCC); send_byte(8'h12);
      check("clken_alu_b", 32'(CLK_EN), 0);
      send_byte(8'h34);
      check("clken_alu_f", 32'(CLK_EN), 1);
      send_byte(8'h02);
      check("clken_alu_wait", 32'(CLK_EN), 1);
      out_valid(16'h0426);
      check("clken_tx_send", 32'(CLK_EN), 0);
      wait_idle("alu");

      // NOP flow under TX backpressure
      exp_alu.push_back(4'h5);
      exp_tx.push_back(8'hEF); exp_tx.push_back(8'hBE);
      send_byte(8'hDD);
      check("clken_nop_f", 32'(CLK_EN), 1);
      send_byte(8'h05);
      TX_FULL = 1'b1;
      tx_mark = tx_seen;
      out_valid(16'hBEEF);
      repeat (3) @(negedge CLK);
      check("bp_no_strobe", 32'(tx_seen - tx_mark), 0);
      check("bp_busy", 32'(BUSY), 1);
      TX_FULL = 1'b0;
      wait_idle("backpressure");
      check("bp_tx_count", 32'(tx_seen - tx_mark), 2);

      // Bad opcode
      exp_err++;
      send_byte(8'h7E);
      check("badop_busy", 32'(BUSY), 0);
      wait_idle("badop");

      // Overrun while waiting for read data
      exp_rd.push_back(4'h7);
      exp_err++;
      exp_tx.push_back(8'hA5);
      send_byte(8'hBB); send_byte(8'h07);
      send_byte(8'h55);
      check("overrun_busy", 32'(BUSY), 1);
      rd_valid(8'hA5);
      wait_idle("overrun");

      // Timeout after a write address with no data byte
      exp_err++;
      send_byte(8'hAA); send_byte(8'h05);
      cyc = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge CLK);
         #1;
         if (FRAME_ERR) begin
            cyc = i;
            break;
         end
      end
      check("timeout_cycle", 32'(cyc), 16);
      check("timeout_busy", 32'(BUSY), 0);
      wait_idle("timeout");

      // Reset during TX_SEND after the first byte
      exp_alu.push_back(4'h1);
      exp_tx.push_back(8'h34);
      send_byte(8'hDD); send_byte(8'h01);
      out_valid(16'h1234);
      cyc = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge CLK);
         #1;
         if (TX_D_VLD) begin
            cyc = i;
            break;
         end
      end
      check("rst_first_tx_seen", 32'(cyc != 0), 1);
      #2;
      RST = 1'b1;
      #1;
      check("rst_outputs_now", all_outputs(), 0);
      tx_mark = tx_seen;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      repeat (10) @(negedge CLK);
      check("rst_no_more_tx", 32'(tx_seen - tx_mark), 0);
      wait_idle("reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
